// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 requester: FSM states, PPROT bits, strobe width.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB4 requester: single-beat command port to APB SETUP/ACCESS transfers with registered response.
// Optional ACCESS wait timeout enabled by defining APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    apb_state_e              state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    accept;

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Ready while idle or on the completing ACCESS cycle; the command goes straight onto the bus regs.
    assign cmd_ready = !PRESET && ((state_q == APB_IDLE) || ((state_q == APB_ACCESS) && PREADY));
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            APB_IDLE: ;
            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = 16'd0;
`endif
            end
            APB_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? DATA_WIDTH'(0) : PRDATA;
                    state_d     = APB_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = DATA_WIDTH'(0);
                    state_d     = APB_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = APB_IDLE;
        endcase

        // Acceptance overrides the idle return so back-to-back transfers keep PSEL high.
        if (accept) begin
            state_d   = APB_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_write ? cmd_wdata : DATA_WIDTH'(0);
            pstrb_d   = cmd_write ? cmd_strb : STRB_W'(0);
            pprot_d   = cmd_prot;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= APB_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
